// File: rtl/ramz_arbiter.sv
// ---------------------------------------------------------------------------
// ramz_arbiter
//   Shares one 128x32 dual-port block RAM (write port A, registered read
//   port B) between two single-beat requesters. Writes are arbitrated onto
//   port A and reads onto port B by two independent round-robin arbiters,
//   so a write and a read can both complete in the same cycle.
//
//   Optional feature macro: RAMZ_ARB_FWD_EN
//     undefined : a read that hits the same address as the granted write
//                 is held off for that cycle and retried next cycle.
//     defined   : such a read is granted anyway and its response returns
//                 the write data through a forwarding register.
//
// Ports
//   clk, rst                 single clock, async active-high reset
//   req_valid_/we_/addr_/wdata_{0,1}   request inputs per requester
//   req_ready_{0,1}          combinational grant (handshake on valid&ready)
//   rsp_valid_/rdata_{0,1}   read response, exactly one cycle after grant
//   ram_addra/wea/dina       RAM write port A
//   ram_addrb/doutb          RAM read port B (doutb registered in the RAM)
// ---------------------------------------------------------------------------
module ramz_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic              req_we_0,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_wea,
  output logic [DATA_W-1:0] ram_dina,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  // Round-robin pick between two candidates: a lone candidate wins; with
  // both present the one that was not granted last time wins.
  function automatic logic pick_idx(input logic [1:0] cand, input logic last);
    logic idx;
    case (cand)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
    return idx;
  endfunction

  logic [1:0]        wcand_s;
  logic [1:0]        rcand_s;
  logic              wgnt_any_s;
  logic              wgnt_idx_s;
  logic              rsel_any_s;
  logic              rsel_idx_s;
  logic              rgnt_any_s;
  logic              hazard_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [ADDR_W-1:0] raddr_s;
  logic [DATA_W-1:0] rdata_s;

  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic tag_q, tag_d;
  logic rvalid_q, rvalid_d;

`ifdef RAMZ_ARB_FWD_EN
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
`endif

  // Candidate sets, both arbiters, request muxes and same-address hazard
  always_comb begin
    wcand_s    = {req_valid_1 & req_we_1, req_valid_0 & req_we_0};
    rcand_s    = {req_valid_1 & ~req_we_1, req_valid_0 & ~req_we_0};
    // Nothing is granted while reset is held
    wgnt_any_s = (|wcand_s) & ~rst;
    wgnt_idx_s = pick_idx(wcand_s, wptr_q);
    rsel_any_s = (|rcand_s) & ~rst;
    rsel_idx_s = pick_idx(rcand_s, rptr_q);

    // Index 0 when idle, so the RAM ports idle on requester 0 values
    if (wgnt_idx_s) begin
      waddr_s = req_addr_1;
      wdata_s = req_wdata_1;
    end else begin
      waddr_s = req_addr_0;
      wdata_s = req_wdata_0;
    end

    if (rsel_idx_s) begin
      raddr_s = req_addr_1;
    end else begin
      raddr_s = req_addr_0;
    end

    // RAM read-during-write at one address is undefined
    hazard_s = wgnt_any_s & rsel_any_s & (waddr_s == raddr_s);

`ifdef RAMZ_ARB_FWD_EN
    rgnt_any_s = rsel_any_s;
`else
    rgnt_any_s = rsel_any_s & ~hazard_s;
`endif
  end

  assign req_ready_0 = (wgnt_any_s & ~wgnt_idx_s) | (rgnt_any_s & ~rsel_idx_s);
  assign req_ready_1 = (wgnt_any_s &  wgnt_idx_s) | (rgnt_any_s &  rsel_idx_s);

  assign ram_wea   = wgnt_any_s;
  assign ram_addra = waddr_s;
  assign ram_dina  = wdata_s;
  assign ram_addrb = raddr_s;

  // Next-state for pointers, response tag and forwarding capture
  always_comb begin
    rvalid_d = rgnt_any_s;

    if (wgnt_any_s) begin
      wptr_d = wgnt_idx_s;
    end else begin
      wptr_d = wptr_q;
    end

    if (rgnt_any_s) begin
      rptr_d = rsel_idx_s;
      tag_d  = rsel_idx_s;
    end else begin
      rptr_d = rptr_q;
      tag_d  = tag_q;
    end

`ifdef RAMZ_ARB_FWD_EN
    fwd_d = hazard_s & rgnt_any_s;
    if (hazard_s) begin
      fwd_data_d = wdata_s;
    end else begin
      fwd_data_d = fwd_data_q;
    end
`endif
  end

  // State registers; reset also drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      tag_q      <= 1'b0;
      rvalid_q   <= 1'b0;
`ifdef RAMZ_ARB_FWD_EN
      fwd_q      <= 1'b0;
      fwd_data_q <= {DATA_W{1'b0}};
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tag_q      <= tag_d;
      rvalid_q   <= rvalid_d;
`ifdef RAMZ_ARB_FWD_EN
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
`endif
    end
  end

  // Response data source: RAM output, or forwarded write data after a hazard
  always_comb begin
`ifdef RAMZ_ARB_FWD_EN
    if (fwd_q) begin
      rdata_s = fwd_data_q;
    end else begin
      rdata_s = ram_doutb;
    end
`else
    rdata_s = ram_doutb;
`endif
  end

  assign rsp_valid_0 = rvalid_q & ~tag_q;
  assign rsp_valid_1 = rvalid_q &  tag_q;
  assign rsp_rdata_0 = rdata_s;
  assign rsp_rdata_1 = rdata_s;

endmodule

// File: tb/tb_ramz_arbiter.sv
// Testbench for ramz_arbiter: behavioural RAM, a transaction-level reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_ramz_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_0, req_valid_1, req_we_0, req_we_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic          ram_wea;
  logic [DW-1:0] ram_dina, ram_doutb;

  logic [DW-1:0] ram [128] = '{default: '0};

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int            m_wptr = 0;
  int            m_rptr = 0;
  logic [DW-1:0] m_mem [128] = '{default: '0};
  bit            pv = 1'b0;
  int            pidx = 0;
  logic [DW-1:0] pdata = '0;
  int            gw, gr;
  logic [AW-1:0] gw_addr;
  logic [DW-1:0] gw_data, gdata;

  ramz_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_we_0(req_we_0), .req_we_1(req_we_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // block RAM: write port A, registered read port B (old data on collision)
  always @(posedge clk) begin
    if (ram_wea) ram[ram_addra] <= ram_dina;
    ram_doutb <= ram[ram_addrb];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int pick(input bit c0, input bit c1, input int last);
    if (c0 && c1) return 1 - last;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  // Negedge: work out what this cycle must look like and compare the DUT
  task automatic model_eval();
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit v [2];
    bit w [2];
    @(negedge clk);
    v[0] = req_valid_0; v[1] = req_valid_1;
    w[0] = req_we_0;    w[1] = req_we_1;
    a[0] = req_addr_0;  a[1] = req_addr_1;
    d[0] = req_wdata_0; d[1] = req_wdata_1;
    gw = -1; gr = -1;
    if (!rst) begin
      gw = pick(v[0] & w[0], v[1] & w[1], m_wptr);
      gr = pick(v[0] & !w[0], v[1] & !w[1], m_rptr);
      if (gr >= 0) gdata = m_mem[a[gr]];
      if (gw >= 0 && gr >= 0 && a[gw] == a[gr]) begin
`ifdef RAMZ_ARB_FWD_EN
        gdata = d[gw];
`else
        gr = -1;
`endif
      end
    end
    if (gw >= 0) begin
      gw_addr = a[gw];
      gw_data = d[gw];
    end
    check("m_ready_0", req_ready_0, (gw == 0 || gr == 0));
    check("m_ready_1", req_ready_1, (gw == 1 || gr == 1));
    check("m_wea", ram_wea, (gw >= 0));
    if (gw >= 0) begin
      check("m_addra", ram_addra, gw_addr);
      check("m_dina", ram_dina, gw_data);
    end
    if (gr >= 0) check("m_addrb", ram_addrb, a[gr]);
    check("m_rsp_valid_0", rsp_valid_0, (!rst && pv && pidx == 0));
    check("m_rsp_valid_1", rsp_valid_1, (!rst && pv && pidx == 1));
    if (!rst && pv) check("m_rsp_rdata", (pidx == 0) ? rsp_rdata_0 : rsp_rdata_1, pdata);
  endtask

  // Posedge: commit the handshakes of this cycle into the model
  task automatic model_update();
    @(posedge clk);
    if (rst) begin
      m_wptr = 0; m_rptr = 0; pv = 1'b0;
    end else begin
      if (gw >= 0) begin
        m_mem[gw_addr] = gw_data;
        m_wptr = gw;
      end
      if (gr >= 0) begin
        pv = 1'b1; pidx = gr; pdata = gdata; m_rptr = gr;
      end else begin
        pv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    model_eval();
    model_update();
  endtask

  task automatic drive(input bit v0, input bit we0, input int a0, input logic [31:0] d0,
                       input bit v1, input bit we1, input int a1, input logic [31:0] d1);
    req_valid_0 = v0; req_we_0 = we0; req_addr_0 = AW'(a0); req_wdata_0 = d0;
    req_valid_1 = v1; req_we_1 = we1; req_addr_1 = AW'(a1); req_wdata_1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    // reset held with a pending write
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    model_eval();
    check("rst_ready_0", req_ready_0, 1'b0);
    check("rst_rsp_valid_0", rsp_valid_0, 1'b0);
    check("rst_rsp_valid_1", rsp_valid_1, 1'b0);
    check("rst_wea", ram_wea, 1'b0);
    model_update();
    cyc();
    rst = 1'b0;
    model_eval();
    check("rel_ready_0", req_ready_0, 1'b1);
    check("rel_wea", ram_wea, 1'b1);
    check("rel_addra", ram_addra, 32'd5);
    model_update();

    // write then read of same address on consecutive cycles
    drive(1, 1, 3, 32'h11111111, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 0, 0, 32'h0, 1, 0, 3, 32'h0);
    model_eval();
    check("wr_rd_ready_1", req_ready_1, 1'b1);
    model_update();
    idle();
    model_eval();
    check("wr_rd_rsp_valid_1", rsp_valid_1, 1'b1);
    check("wr_rd_rsp_rdata_1", rsp_rdata_1, 32'h11111111);
    check("wr_rd_rsp_valid_0", rsp_valid_0, 1'b0);
    model_update();

    // write contention after reset: grants alternate 1,0,1,0
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    drive(1, 1, 10, 32'hAAAA0000, 1, 1, 20, 32'hBBBB0000);
    for (int i = 0; i < 4; i++) begin
      model_eval();
      check("alt_ready_1", req_ready_1, (i % 2 == 0));
      check("alt_ready_0", req_ready_0, (i % 2 == 1));
      model_update();
    end
    idle();
    cyc();

    // concurrent write and read to different addresses
    drive(1, 1, 7, 32'hA5A5A5A5, 1, 0, 9, 32'h0);
    model_eval();
    check("par_ready_0", req_ready_0, 1'b1);
    check("par_ready_1", req_ready_1, 1'b1);
    model_update();
    idle();
    model_eval();
    check("par_rsp_valid_1", rsp_valid_1, 1'b1);
    check("par_rsp_rdata_1", rsp_rdata_1, 32'h0);
    model_update();

    // read contention exercising the read pointer
    drive(1, 0, 10, 32'h0, 1, 0, 20, 32'h0);
    cyc();
    cyc();
    idle();
    cyc();

    // same-address hazard
    drive(1, 1, 12, 32'h12345678, 1, 0, 12, 32'h0);
    model_eval();
    check("hz_ready_0", req_ready_0, 1'b1);
`ifdef RAMZ_ARB_FWD_EN
    check("hz_ready_1", req_ready_1, 1'b1);
    model_update();
    idle();
`else
    check("hz_ready_1", req_ready_1, 1'b0);
    model_update();
    drive(0, 0, 0, 32'h0, 1, 0, 12, 32'h0);
    model_eval();
    check("hz_retry_ready_1", req_ready_1, 1'b1);
    model_update();
    idle();
`endif
    model_eval();
    check("hz_rsp_valid_1", rsp_valid_1, 1'b1);
    check("hz_rsp_rdata_1", rsp_rdata_1, 32'h12345678);
    model_update();

    // reset right after a read handshake drops the response
    drive(1, 0, 5, 32'h0, 0, 0, 0, 32'h0);
    model_eval();
    check("rr_ready_0", req_ready_0, 1'b1);
    model_update();
    rst = 1'b1;
    idle();
    model_eval();
    check("rr_rsp_valid_0", rsp_valid_0, 1'b0);
    model_update();
    rst = 1'b0;
    drive(1, 0, 5, 32'h0, 0, 0, 0, 32'h0);
    cyc();
    idle();
    model_eval();
    check("rr_re_rsp_valid_0", rsp_valid_0, 1'b1);
    check("rr_re_rsp_rdata_0", rsp_rdata_0, 32'hDEADBEEF);
    model_update();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
